// File: rtl/restoring_divider_unit.sv
// restoring_divider_unit
//   Sequential unsigned restoring (shift-and-subtract) divider. One quotient
//   bit is resolved per clock. It uses the same start/done handshake as the
//   shift-and-add multiplier.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; abandons any operation in flight
//   start        request, sampled only while idle
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   busy         high while iterating
//   done         one-cycle pulse: quotient/remainder/div_by_zero are valid
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered flag, valid with done, held like quotient
module restoring_divider_unit #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH:0]   r;        // partial remainder, one bit wider than operands
    logic [WIDTH-1:0] q;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d;        // captured divisor
    logic [CW-1:0]    count;    // iterations still to perform

    logic             accept;
    logic             zero_div;
    logic             last_iter;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: shift {R,Q} left, trial-subtract D and keep the
    // difference only when it did not borrow. R < D always holds between
    // steps, so the bit shifted out of R's top is always zero.
    always_comb begin
        r_shift   = {r[WIDTH-1:0], q[WIDTH-1]};
        trial     = {1'b0, r_shift} - {2'b00, d};
        trial_neg = trial[WIDTH+1];
        r_next    = trial_neg ? r_shift : trial[WIDTH:0];
        q_next    = {q[WIDTH-2:0], ~trial_neg};
    end

    always_comb begin
        accept    = (state == IDLE) && start;
        zero_div  = (divisor == '0);
        last_iter = (count == CW'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: registered state only, no path from the inputs
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                if (zero_div) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end else begin
                    r     <= '0;
                    q     <= dividend;
                    d     <= divisor;
                    count <= CW'(WIDTH);
                end
            end else if (state == RUN) begin
                r     <= r_next;
                q     <= q_next;
                count <= count - CW'(1);
                if (last_iter) begin
                    quotient    <= q_next;
                    remainder   <= r_next[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule
